// File: rtl/eng_outbuf.sv
// Output buffer behind the engine: stores whole parity words in a small FIFO
// and streams the first m_cfg units of each word, one unit per cycle, over valid/ready.
module eng_outbuf #(
    parameter int W                      = 4,
    parameter int PACKET_LENGTH          = 2,
    parameter int PCK_TREE_XOR_UNITS_NUM = 128,
    parameter int DEPTH                  = 4,
    parameter int UNIT_IDX_W             = $clog2(PCK_TREE_XOR_UNITS_NUM)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     outbuf_clr,
    input  logic                     m_cfg_wr,
    input  logic [UNIT_IDX_W:0]      m_cfg_din,
    input  logic [PACKET_LENGTH-1:0] eng_outbuf_dout_reg [0:PCK_TREE_XOR_UNITS_NUM-1][0:W-1],
    input  logic                     eng_outbuf_wr_req,
    output logic                     outbuf_eng_wr_ack,
    output logic                     outbuf_eng_full,
    output logic                     outbuf_empty,
    output logic [PACKET_LENGTH-1:0] outbuf_dout [0:W-1],
    output logic [UNIT_IDX_W-1:0]    outbuf_dout_idx,
    output logic                     outbuf_dout_last,
    output logic                     outbuf_dout_val,
    input  logic                     user_outbuf_rdy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CFG_W = UNIT_IDX_W + 1;
    localparam logic [CFG_W-1:0] CFG_MAX = CFG_W'(PCK_TREE_XOR_UNITS_NUM);

    typedef enum logic {IDLE, SEND} state_t;

    logic [PACKET_LENGTH-1:0] mem [0:DEPTH-1][0:PCK_TREE_XOR_UNITS_NUM-1][0:W-1];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_next;
    logic [UNIT_IDX_W-1:0]    unit_idx;
    logic [CFG_W-1:0]         m_cfg;
    logic [CFG_W-1:0]         m_cfg_sat;
    logic [CFG_W-1:0]         m_cfg_eff;
    logic                     push;
    logic                     pop;
    state_t                   state;

    assign push            = eng_outbuf_wr_req & ~outbuf_eng_full & ~outbuf_clr;
    assign pop             = outbuf_dout_val & user_outbuf_rdy & outbuf_dout_last;
    assign outbuf_eng_full = (count == CNT_W'(DEPTH));
    assign outbuf_empty    = (count == '0);
    assign outbuf_dout_idx = unit_idx;

    // A config write landing with the first push of an empty buffer already governs that word.
    assign m_cfg_sat = ((m_cfg_din == '0) || (m_cfg_din > CFG_MAX)) ? CFG_MAX : m_cfg_din;
    assign m_cfg_eff = (m_cfg_wr && outbuf_empty) ? m_cfg_sat : m_cfg;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        for (int w = 0; w < W; w++) begin
            outbuf_dout[w] = mem[rd_ptr][unit_idx][w];
        end
    end

    // Storage is deliberately left out of reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int u = 0; u < PCK_TREE_XOR_UNITS_NUM; u++) begin
                for (int w = 0; w < W; w++) begin
                    mem[wr_ptr][u][w] <= eng_outbuf_dout_reg[u][w];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            unit_idx          <= '0;
            m_cfg             <= CFG_MAX;
            state             <= IDLE;
            outbuf_eng_wr_ack <= 1'b0;
            outbuf_dout_val   <= 1'b0;
            outbuf_dout_last  <= 1'b0;
        end else if (outbuf_clr) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            unit_idx          <= '0;
            state             <= IDLE;
            outbuf_eng_wr_ack <= 1'b0;
            outbuf_dout_val   <= 1'b0;
            outbuf_dout_last  <= 1'b0;
        end else begin
            outbuf_eng_wr_ack <= push;
            count             <= count_next;
            m_cfg             <= m_cfg_eff;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // Using count_next lets a push into an empty buffer show up on the very next cycle.
            case (state)
                IDLE: begin
                    if (count_next != '0) begin
                        state            <= SEND;
                        outbuf_dout_val  <= 1'b1;
                        unit_idx         <= '0;
                        outbuf_dout_last <= (m_cfg_eff == CFG_W'(1));
                    end
                end
                SEND: begin
                    if (user_outbuf_rdy) begin
                        if (outbuf_dout_last) begin
                            rd_ptr   <= rd_ptr + PTR_W'(1);
                            unit_idx <= '0;
                            if (count_next != '0) begin
                                outbuf_dout_last <= (m_cfg_eff == CFG_W'(1));
                            end else begin
                                state            <= IDLE;
                                outbuf_dout_val  <= 1'b0;
                                outbuf_dout_last <= 1'b0;
                            end
                        end else begin
                            unit_idx         <= unit_idx + UNIT_IDX_W'(1);
                            outbuf_dout_last <= (({1'b0, unit_idx} + CFG_W'(2)) == m_cfg_eff);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eng_outbuf.sv
// Randomized and directed bench for eng_outbuf: a word-level queue model predicts
// flags and the unit stream, and a negedge monitor compares against a scoreboard.
module tb_eng_outbuf;

    localparam int W     = 4;
    localparam int PL    = 2;
    localparam int N     = 128;
    localparam int DEPTH = 4;
    localparam int IW    = $clog2(N);

    typedef struct {
        logic [W*PL-1:0] data;
        int              idx;
        bit              last;
    } unit_t;

    logic          clk;
    logic          rstn;
    logic          clr;
    logic          cfg_wr;
    logic [IW:0]   cfg_din;
    logic [PL-1:0] din [0:N-1][0:W-1];
    logic          wr_req;
    logic          ack;
    logic          full;
    logic          empty;
    logic [PL-1:0] dout [0:W-1];
    logic [IW-1:0] idx;
    logic          last;
    logic          val;
    logic          rdy;

    int    total = 0;
    int    bad   = 0;
    int    words_m[$];
    int    sent_m;
    int    mcfg_m;
    bit    ack_m;
    unit_t exp_q[$];

    eng_outbuf #(
        .W(W), .PACKET_LENGTH(PL), .PCK_TREE_XOR_UNITS_NUM(N), .DEPTH(DEPTH), .UNIT_IDX_W(IW)
    ) dut (
        .clk(clk), .rstn(rstn), .outbuf_clr(clr), .m_cfg_wr(cfg_wr), .m_cfg_din(cfg_din),
        .eng_outbuf_dout_reg(din), .eng_outbuf_wr_req(wr_req), .outbuf_eng_wr_ack(ack),
        .outbuf_eng_full(full), .outbuf_empty(empty), .outbuf_dout(dout),
        .outbuf_dout_idx(idx), .outbuf_dout_last(last), .outbuf_dout_val(val),
        .user_outbuf_rdy(rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of words, each remembered only by how many units it will emit.
    always @(posedge clk or negedge rstn) begin
        bit    do_push;
        unit_t e;
        if (!rstn) begin
            words_m.delete();
            exp_q.delete();
            sent_m = 0;
            mcfg_m = N;
            ack_m  = 1'b0;
        end else if (clr) begin
            words_m.delete();
            exp_q.delete();
            sent_m = 0;
            ack_m  = 1'b0;
        end else begin
            do_push = wr_req && (words_m.size() < DEPTH);
            if (cfg_wr && words_m.size() == 0) begin
                mcfg_m = (cfg_din == 0 || int'(cfg_din) > N) ? N : int'(cfg_din);
            end
            if (words_m.size() > 0 && rdy) begin
                sent_m++;
                if (sent_m == words_m[0]) begin
                    void'(words_m.pop_front());
                    sent_m = 0;
                end
            end
            if (do_push) begin
                words_m.push_back(mcfg_m);
                for (int u = 0; u < mcfg_m; u++) begin
                    for (int w = 0; w < W; w++) e.data[w*PL +: PL] = din[u][w];
                    e.idx  = u;
                    e.last = (u == mcfg_m - 1);
                    exp_q.push_back(e);
                end
            end
            ack_m = do_push;
        end
    end

    // Monitor: flags against the model, unit stream against the scoreboard.
    always @(negedge clk) begin
        logic [W*PL-1:0] got;
        unit_t           h;
        if (!rstn) begin
            check_output("rst_val", val, 1'b0);
            check_output("rst_ack", ack, 1'b0);
            check_output("rst_empty", empty, 1'b1);
            check_output("rst_full", full, 1'b0);
            check_output("rst_idx", idx, 0);
        end else begin
            check_output("ack", ack, ack_m);
            check_output("full", full, words_m.size() == DEPTH);
            check_output("empty", empty, words_m.size() == 0);
            check_output("val", val, words_m.size() != 0);
            if (val) begin
                if (exp_q.size() == 0) begin
                    check_output("sb_underflow", 1, 0);
                end else begin
                    h = exp_q[0];
                    for (int w = 0; w < W; w++) got[w*PL +: PL] = dout[w];
                    check_output("dout", got, h.data);
                    check_output("idx", idx, h.idx);
                    check_output("last", last, h.last);
                    if (rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic make_word(input bit rnd);
        for (int u = 0; u < N; u++) begin
            for (int w = 0; w < W; w++) begin
                din[u][w] = rnd ? PL'($urandom) : PL'(u);
            end
        end
    endtask

    task automatic apply_stimulus(input bit wr, input bit r, input bit c);
        wr_req = wr;
        rdy    = r;
        clr    = c;
        cfg_wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int v, input bit r);
        wr_req  = 1'b0;
        rdy     = r;
        clr     = 1'b0;
        cfg_wr  = 1'b1;
        cfg_din = (IW+1)'(v);
        @(posedge clk);
        #1;
        cfg_wr  = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (words_m.size() != 0 && n < max_cycles) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            n++;
        end
        if (words_m.size() != 0) check_output("drain_timeout", words_m.size(), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; cfg_wr = 1'b0; cfg_din = '0; wr_req = 1'b0; rdy = 1'b0;
        make_word(1'b0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);

        // Single word of three units, pattern data.
        set_cfg(3, 1'b1);
        make_word(1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        repeat (5) apply_stimulus(1'b0, 1'b1, 1'b0);

        // Fill to full with a 5th request refused, then one-unit drain.
        set_cfg(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            make_word(1'b1);
            apply_stimulus(1'b1, 1'b0, 1'b0);
        end
        wait_drain(10);

        // Back-pressure with rdy toggling.
        set_cfg(4, 1'b0);
        for (int i = 0; i < 2; i++) begin
            make_word(1'b1);
            apply_stimulus(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, i[0] == 1'b0, 1'b0);
        wait_drain(20);

        // Push coinciding with the final handshake of a word.
        set_cfg(3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            make_word(1'b1);
            apply_stimulus(1'b1, 1'b0, 1'b0);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        make_word(1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        wait_drain(20);

        // Config writes: ignored while busy, zero saturates to the full unit count.
        make_word(1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        set_cfg(5, 1'b1);
        wait_drain(10);
        set_cfg(0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            make_word(1'b1);
            apply_stimulus(1'b1, 1'b0, 1'b0);
        end
        wait_drain(300);

        // Flush mid-word with a concurrent write request.
        set_cfg(4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            make_word(1'b1);
            apply_stimulus(1'b1, 1'b0, 1'b0);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0);
        make_word(1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        make_word(1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        wait_drain(10);

        // Random traffic with occasional flushes.
        set_cfg(int'($urandom_range(1, 6)), 1'b0);
        for (int i = 0; i < 400; i++) begin
            make_word(1'b1);
            apply_stimulus($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        wait_drain(100);

        // Asynchronous reset in the middle of a stream.
        set_cfg(3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            make_word(1'b1);
            apply_stimulus(1'b1, 1'b1, 1'b0);
        end
        #2 rstn = 1'b0;
        #1;
        check_output("async_val", val, 1'b0);
        check_output("async_last", last, 1'b0);
        check_output("async_idx", idx, 0);
        check_output("async_empty", empty, 1'b1);
        check_output("async_ack", ack, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        make_word(1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        wait_drain(N + 10);

        check_output("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eng_outbuf.md
Name: eng_outbuf

Overview:
- Output buffer directly downstream of the engine pipeline.
- Accepts one full parity word per write from the engine: PCK_TREE_XOR_UNITS_NUM units × W packets of PACKET_LENGTH bits.
- Stores words in a DEPTH-entry FIFO and drives back-pressure (outbuf_eng_full) plus a write ack to the engine.
- Streams stored words to the consumer one tree-xor unit per cycle over a valid/ready interface; only the first m_cfg units of each word are sent.

Parameters:
W, 4, bits per symbol word (packet rows per unit)
PACKET_LENGTH, 2, bits per packet
PCK_TREE_XOR_UNITS_NUM, 128, units per engine output word
DEPTH, 4, FIFO entries (power of 2, ≥2)
UNIT_IDX_W, $clog2(PCK_TREE_XOR_UNITS_NUM), unit index width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
outbuf_clr  in  1  synchronous flush; clears FIFO and serializer
m_cfg_wr  in  1  load m_cfg_din
m_cfg_din  in  UNIT_IDX_W+1  units to emit per word (1..PCK_TREE_XOR_UNITS_NUM)
eng_outbuf_dout_reg  in  [PACKET_LENGTH-1:0] [0:PCK_TREE_XOR_UNITS_NUM-1][0:W-1]  engine parity word
eng_outbuf_wr_req  in  1  write request
outbuf_eng_wr_ack  out  1  one-cycle pulse, word accepted
outbuf_eng_full  out  1  FIFO full
outbuf_empty  out  1  FIFO empty and serializer idle
outbuf_dout  out  [PACKET_LENGTH-1:0] [0:W-1]  current unit's packets
outbuf_dout_idx  out  UNIT_IDX_W  unit index of outbuf_dout
outbuf_dout_last  out  1  last unit of the current word
outbuf_dout_val  out  1  output valid
user_outbuf_rdy  in  1  consumer ready

Behaviour:
- Reset (rstn low, async) values:
  - wr/rd pointers, count, unit index: 0
  - m_cfg register: PCK_TREE_XOR_UNITS_NUM
  - outbuf_eng_wr_ack 0, outbuf_eng_full 0, outbuf_empty 1, outbuf_dout_val 0, outbuf_dout_last 0, outbuf_dout_idx 0
  - FSM: IDLE
  - Memory contents are not reset.
- Push:
  - Condition: eng_outbuf_wr_req & ~outbuf_eng_full & ~outbuf_clr.
  - Writes the whole word to mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - outbuf_eng_wr_ack is registered and pulses on the cycle after the push.
  - wr_req while full is ignored; no ack, no state change.
- Full/empty flags:
  - outbuf_eng_full = (count == DEPTH), driven from the registered count.
  - outbuf_empty = (count == 0).
- FSM:
  - IDLE: dout_val = 0. Go to SEND when count != 0.
  - SEND:
    - outbuf_dout = mem[rd_ptr][unit_idx]; outbuf_dout_val = 1; outbuf_dout_idx = unit_idx.
    - outbuf_dout_last = (unit_idx == m_cfg − 1).
    - On val & rdy & ~last: unit_idx increments.
    - On val & rdy & last (pop): unit_idx → 0, rd_ptr increments mod DEPTH. Stay in SEND if count after the pop is nonzero, else go to IDLE.
- Latency: a word pushed in cycle N gives dout_val = 1 in cycle N+1 if the FIFO was empty.
- Throughput: one unit per cycle while rdy is held high; no bubble between consecutive words.
- Simultaneous push and pop in the same cycle: count unchanged, pointers both advance.
  - Full is evaluated from the pre-update count, so a word popped while full frees space only on the next cycle.
- Data and index stability: while val & ~rdy, outbuf_dout, outbuf_dout_idx and outbuf_dout_last hold steady.
- m_cfg:
  - m_cfg_wr is accepted only when outbuf_empty = 1; it is ignored otherwise.
  - Values 0 or greater than PCK_TREE_XOR_UNITS_NUM saturate to PCK_TREE_XOR_UNITS_NUM.
- outbuf_clr (synchronous, highest priority after rstn):
  - Next cycle: pointers, count and unit_idx are 0, FSM is IDLE, val = 0, ack = 0.
  - A wr_req in the same cycle as clr is dropped.
  - m_cfg is retained.
- Async rstn assertion mid-stream returns all outputs to their reset values immediately.

Test Plan:
- Single word, m_cfg = 3, rdy = 1: push word with unit u packets = u[1:0] → ack pulse at N+1; dout_val at N+1..N+3; idx 0,1,2; last only at idx 2; outbuf_empty = 1 at N+4.
- Fill: 4 back-to-back pushes, rdy = 0 → 4 acks; full = 1 after the 4th push. 5th wr_req gives no ack and count stays 4. Then rdy = 1 with m_cfg = 1 → 4 words drain in 4 cycles in push order.
- Back-pressure: m_cfg = 4, toggle rdy 1,0,1,0… → idx advances only on rdy-high cycles; dout is stable while rdy is low; last asserts exactly once per word.
- Simultaneous: count = 2 and last handshake coincides with a push → count stays 2; no data loss; the pushed word is the 3rd emitted.
- m_cfg_wr = 5 while non-empty → ignored, words still emit 3 units. m_cfg_wr = 0 while empty → m_cfg = 128.
- outbuf_clr mid-word (idx = 1, count = 3) plus a concurrent wr_req → next cycle val = 0, empty = 1, full = 0, no ack. A following push streams from idx 0.
